eth_arp_responder: RTL and testbench
====================================

ETH_ARP_RESPONDER -- requirements
Module: eth_arp_responder

Interface
REQ-001 Parameter DES_IP, default {8'd192,8'd168,8'd1,8'd102}: peer IP used in outgoing ARP requests.
REQ-002 Parameter TIMEOUT_CYC, default 125_000_000: cycles to wait for an ARP reply before retry or give-up.
REQ-003 Parameter MAX_RETRY, default 3: request retries after the first attempt.
REQ-004 clk  in  1  single clock (GMII tx clock domain); all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 arp_rx_done  in  1  one-cycle pulse: ARP frame parsed, src_mac/src_ip/arp_rx_type valid.
REQ-007 arp_rx_type  in  1  0 = request, 1 = reply.
REQ-008 src_mac  in  48  sender MAC of the received frame.
REQ-009 src_ip  in  32  sender IP of the received frame.
REQ-010 tx_done  in  1  one-cycle pulse: ARP transmitter finished a frame.
REQ-011 req_trig  in  1  one-cycle pulse: user requests resolution of DES_IP.
REQ-012 arp_tx_en  out  1  one-cycle pulse starting an ARP transmission.
REQ-013 arp_tx_type  out  1  0 = request, 1 = reply; stable from arp_tx_en until tx_done.
REQ-014 des_mac  out  48  target MAC for the frame; stable from arp_tx_en until tx_done.
REQ-015 des_ip  out  32  target IP for the frame; stable from arp_tx_en until tx_done.
REQ-016 peer_valid  out  1  level: peer_mac/peer_ip hold a resolved entry.
REQ-017 peer_mac  out  48  cached peer MAC.
REQ-018 peer_ip  out  32  cached peer IP.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 resolve_fail  out  1  one-cycle pulse when all request attempts time out.

Function
REQ-021 FSM states: IDLE, TX_START, TX_WAIT, WAIT_REPLY; state encoding from the package.
REQ-022 IDLE: a pending reply takes priority over a pending request; either moves to TX_START.
REQ-023 TX_START: arp_tx_en=1 for exactly one cycle with type/des_mac/des_ip loaded; next state TX_WAIT.
REQ-024 TX_WAIT: on tx_done, a reply returns to IDLE; a request moves to WAIT_REPLY with timer cleared.
REQ-025 Reply: des_mac/des_ip = src_mac/src_ip latched from the triggering request; arp_tx_type=1.
REQ-026 Request: des_mac=48'hff_ff_ff_ff_ff_ff, des_ip=DES_IP, arp_tx_type=0.
REQ-027 arp_rx_done with type 0 in any state sets a one-deep reply-pending flag and latches src_mac/src_ip; a second request before service overwrites the latch (latest wins).
REQ-028 arp_rx_done with type 1 and src_ip==DES_IP in any state: load peer_mac/peer_ip, set peer_valid next cycle; in WAIT_REPLY go to IDLE.
REQ-029 Received replies whose IP does not match DES_IP are ignored.
REQ-030 Every received request (type 0) also refreshes the cache when src_ip==DES_IP.
REQ-031 req_trig sets request-pending; ignored while a request is already pending or in flight.
REQ-032 Same-cycle req_trig and arp_rx_done request: both flags set; reply sent first.
REQ-033 WAIT_REPLY: timer counts to TIMEOUT_CYC-1; on expiry retry (REQ-040) or pulse resolve_fail and go to IDLE.
REQ-034 A reply pending during WAIT_REPLY is serviced only after WAIT_REPLY exits; the timer is not paused.
REQ-035 Timer width = $clog2(TIMEOUT_CYC); retry counter width = $clog2(MAX_RETRY+1); no wrap-around permitted.

Reset
REQ-036 On rst_n low: state IDLE, arp_tx_en=0, arp_tx_type=0, des_mac=0, des_ip=0, peer_valid=0, peer_mac=0, peer_ip=0, busy=0, resolve_fail=0, all flags/counters 0.
REQ-037 Reset mid-transmission abandons the transaction; no arp_tx_en until a new event after release.
REQ-038 First event accepted on the first clk edge after rst_n deasserts.

Configuration
REQ-039 Macro ARP_RETRY_EN selects retry behaviour.
REQ-040 Defined: on timeout with retries used < MAX_RETRY, increment counter and go to TX_START; else resolve_fail.
REQ-041 Undefined: first timeout pulses resolve_fail and returns to IDLE; MAX_RETRY unused; no retry counter synthesized.

Structure
REQ-042 Package eth_arp_pkg: state typedef, ARP_TYPE_REQ=1'b0, ARP_TYPE_REPLY=1'b1, BCAST_MAC constant.
REQ-043 One sub-module arp_timeout_timer (clear, enable, expired pulse; parameter TIMEOUT_CYC).

Verification (TIMEOUT_CYC=100, MAX_RETRY=2 in bench)
REQ-044 rx request src_ip=192.168.1.102, src_mac=A0:B1:C2:D3:E4:F5 -> arp_tx_en pulse 2 cycles later, type 1, des_mac/des_ip equal source.
REQ-045 req_trig; tx_done; rx reply from 192.168.1.102 within 50 cycles -> request broadcast to DES_IP, peer_valid=1, peer_mac matches.
REQ-046 req_trig, no reply, ARP_RETRY_EN defined -> 3 requests total then resolve_fail pulse; undefined -> 1 request then resolve_fail.
REQ-047 req_trig and rx request in same cycle -> reply frame first, then request frame after tx_done.
REQ-048 rst_n low during TX_WAIT -> all outputs 0, busy=0, no further arp_tx_en.
REQ-049 rx reply from 192.168.1.55 in WAIT_REPLY -> ignored, peer_valid stays 0, timeout proceeds.

Source files
------------

// File: rtl/eth_arp_pkg.sv
// eth_arp_pkg: shared state encoding and ARP constants for the ARP responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eth_arp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_TX_START   = 2'd1,
        ST_TX_WAIT    = 2'd2,
        ST_WAIT_REPLY = 2'd3
    } arp_state_t;

    localparam logic        ARP_TYPE_REQ   = 1'b0;
    localparam logic        ARP_TYPE_REPLY = 1'b1;
    localparam logic [47:0] BCAST_MAC      = 48'hff_ff_ff_ff_ff_ff;

endpackage

// File: rtl/arp_timeout_timer.sv
// arp_timeout_timer: counts enabled cycles and flags the last one of a TIMEOUT_CYC window.
// Latency: o_expired is combinational, high on the TIMEOUT_CYC-th enabled cycle after i_clr.
// Backpressure: none; the count saturates at TIMEOUT_CYC-1 and never wraps.
module arp_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 125_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int unsigned    W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] r_cnt;

    // Count enabled cycles, holding at the final value so the counter cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/eth_arp_responder.sv
// eth_arp_responder: answers ARP requests and resolves DES_IP to a cached peer MAC.
// Latency: arp_tx_en pulses two cycles after the arp_rx_done/req_trig that causes it (when idle).
// Backpressure: one frame in flight; one-deep reply/request pending flags; build option ARP_RETRY_EN.
module eth_arp_responder
    import eth_arp_pkg::*;
#(
    parameter logic [31:0] DES_IP      = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter int unsigned TIMEOUT_CYC = 125_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        tx_done,
    input  logic        req_trig,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        peer_valid,
    output logic [47:0] peer_mac,
    output logic [31:0] peer_ip,
    output logic        busy,
    output logic        resolve_fail
);
    arp_state_t  r_state;
    logic        r_rep_pend;
    logic [47:0] r_rep_mac;
    logic [31:0] r_rep_ip;
    logic        r_req_pend;
    logic        r_tx_en;
    logic        r_tx_type;
    logic [47:0] r_des_mac;
    logic [31:0] r_des_ip;
    logic        r_peer_valid;
    logic [47:0] r_peer_mac;
    logic [31:0] r_peer_ip;
    logic        r_fail;

`ifdef ARP_RETRY_EN
    localparam int unsigned  RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    logic [RW-1:0] r_retry_cnt;
`endif

    logic w_rx_req;
    logic w_rx_peer;
    logic w_rx_peer_reply;
    logic w_req_busy;
    logic w_take_reply;
    logic w_take_req;
    logic w_timer_clr;
    logic w_timer_en;
    logic w_expired;

    assign w_rx_req        = arp_rx_done && (arp_rx_type == ARP_TYPE_REQ);
    assign w_rx_peer       = arp_rx_done && (src_ip == DES_IP);
    assign w_rx_peer_reply = w_rx_peer && (arp_rx_type == ARP_TYPE_REPLY);
    // The current frame type tells whether a request is in flight outside IDLE.
    assign w_req_busy      = r_req_pend || ((r_state != ST_IDLE) && (r_tx_type == ARP_TYPE_REQ));
    assign w_take_reply    = (r_state == ST_IDLE) && r_rep_pend;
    assign w_take_req      = (r_state == ST_IDLE) && !r_rep_pend && r_req_pend;
    assign w_timer_clr     = (r_state == ST_TX_WAIT);
    assign w_timer_en      = (r_state == ST_WAIT_REPLY);

    arp_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_timer_clr),
        .i_en      (w_timer_en),
        .o_expired (w_expired)
    );

    // Latch the most recent ARP request sender; a new request beats a same-cycle service.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_pend <= 1'b0;
            r_rep_mac  <= '0;
            r_rep_ip   <= '0;
        end else if (w_rx_req) begin
            r_rep_pend <= 1'b1;
            r_rep_mac  <= src_mac;
            r_rep_ip   <= src_ip;
        end else if (w_take_reply) begin
            r_rep_pend <= 1'b0;
        end
    end

    // Record a user resolve request unless one is already queued or on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pend <= 1'b0;
        end else if (w_take_req) begin
            r_req_pend <= 1'b0;
        end else if (req_trig && !w_req_busy) begin
            r_req_pend <= 1'b1;
        end
    end

    // Any ARP frame from the peer IP refreshes the cached entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peer_valid <= 1'b0;
            r_peer_mac   <= '0;
            r_peer_ip    <= '0;
        end else if (w_rx_peer) begin
            r_peer_valid <= 1'b1;
            r_peer_mac   <= src_mac;
            r_peer_ip    <= src_ip;
        end
    end

    // Transaction FSM: picks the next frame, holds its fields, waits for the peer reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tx_en     <= 1'b0;
            r_tx_type   <= ARP_TYPE_REQ;
            r_des_mac   <= '0;
            r_des_ip    <= '0;
            r_fail      <= 1'b0;
`ifdef ARP_RETRY_EN
            r_retry_cnt <= '0;
`endif
        end else begin
            r_tx_en <= 1'b0;
            r_fail  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take_reply) begin
                        r_state   <= ST_TX_START;
                        r_tx_en   <= 1'b1;
                        r_tx_type <= ARP_TYPE_REPLY;
                        r_des_mac <= r_rep_mac;
                        r_des_ip  <= r_rep_ip;
                    end else if (w_take_req) begin
                        r_state     <= ST_TX_START;
                        r_tx_en     <= 1'b1;
                        r_tx_type   <= ARP_TYPE_REQ;
                        r_des_mac   <= BCAST_MAC;
                        r_des_ip    <= DES_IP;
`ifdef ARP_RETRY_EN
                        r_retry_cnt <= '0;
`endif
                    end
                end
                ST_TX_START: begin
                    r_state <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (tx_done) begin
                        r_state <= (r_tx_type == ARP_TYPE_REPLY) ? ST_IDLE : ST_WAIT_REPLY;
                    end
                end
                ST_WAIT_REPLY: begin
                    if (w_rx_peer_reply) begin
                        r_state <= ST_IDLE;
                    end else if (w_expired) begin
`ifdef ARP_RETRY_EN
                        if (r_retry_cnt < RETRY_LIMIT) begin
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                            r_state     <= ST_TX_START;
                            r_tx_en     <= 1'b1;
                        end else begin
                            r_fail  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
`else
                        r_fail  <= 1'b1;
                        r_state <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign arp_tx_en    = r_tx_en;
    assign arp_tx_type  = r_tx_type;
    assign des_mac      = r_des_mac;
    assign des_ip       = r_des_ip;
    assign peer_valid   = r_peer_valid;
    assign peer_mac     = r_peer_mac;
    assign peer_ip      = r_peer_ip;
    assign busy         = (r_state != ST_IDLE);
    assign resolve_fail = r_fail;

endmodule

// File: tb/tb_eth_arp_responder.sv
// tb_eth_arp_responder: randomized scenarios against a frame-level reference model.
// Latency: n/a (bench).
// Backpressure: the bench emulates the ARP transmitter with random tx_done delays.
module tb_eth_arp_responder;

    localparam int          TO      = 100;
    localparam int          MR      = 2;
    localparam logic [31:0] PEER_IP = {8'd192, 8'd168, 8'd1, 8'd102};
`ifdef ARP_RETRY_EN
    localparam int          N_ATT   = MR + 1;
`else
    localparam int          N_ATT   = 1;
`endif

    typedef struct packed {
        logic        typ;
        logic [47:0] mac;
        logic [31:0] ip;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp_rx_done = 1'b0;
    logic        arp_rx_type = 1'b0;
    logic [47:0] src_mac = '0;
    logic [31:0] src_ip = '0;
    logic        tx_done = 1'b0;
    logic        req_trig = 1'b0;
    logic        arp_tx_en, arp_tx_type, peer_valid, busy, resolve_fail;
    logic [47:0] des_mac, peer_mac;
    logic [31:0] des_ip, peer_ip;

    int total = 0;
    int bad   = 0;

    // Reference model state: expected frame order and expected peer cache.
    frame_t      exp_q[$];
    logic        m_valid = 1'b0;
    logic [47:0] m_mac   = '0;
    logic [31:0] m_ip    = '0;

    // Observations collected by the monitor.
    int     cyc = 0, n_frames = 0, n_txd = 0, n_fail = 0, t_txd = 0, t_fail = 0;
    bit     in_tx = 1'b0;
    bit     tx_hold = 1'b0;
    frame_t cur;

    eth_arp_responder #(
        .DES_IP      (PEER_IP),
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (MR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arp_rx_done  (arp_rx_done),
        .arp_rx_type  (arp_rx_type),
        .src_mac      (src_mac),
        .src_ip       (src_ip),
        .tx_done      (tx_done),
        .req_trig     (req_trig),
        .arp_tx_en    (arp_tx_en),
        .arp_tx_type  (arp_tx_type),
        .des_mac      (des_mac),
        .des_ip       (des_ip),
        .peer_valid   (peer_valid),
        .peer_mac     (peer_mac),
        .peer_ip      (peer_ip),
        .busy         (busy),
        .resolve_fail (resolve_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=not_seen required=seen_within_bound", nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rmac();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    function automatic frame_t req_frame();
        return '{typ: 1'b0, mac: 48'hffff_ffff_ffff, ip: PEER_IP};
    endfunction

    // Monitor: every cycle checks frames, field stability and the peer cache.
    always @(negedge clk) begin
        frame_t e;
        cyc++;
        if (!rst_n) begin
            in_tx = 1'b0;
        end else begin
            if (in_tx)
                chk("tx_fields_stable", 128'({arp_tx_type, des_mac, des_ip}), 128'(cur));
            if (arp_tx_en) begin
                n_frames++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame actual=type%0d/%h/%h required=no_frame",
                             arp_tx_type, des_mac, des_ip);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", 128'({arp_tx_type, des_mac, des_ip}), 128'(e));
                end
                cur   = '{typ: arp_tx_type, mac: des_mac, ip: des_ip};
                in_tx = 1'b1;
            end
            if (tx_done) begin
                in_tx = 1'b0;
                n_txd++;
                t_txd = cyc;
            end
            if (resolve_fail) begin
                n_fail++;
                t_fail = cyc;
            end
            chk("peer_valid", 128'(peer_valid), 128'(m_valid));
            if (m_valid)
                chk("peer_entry", 128'({peer_mac, peer_ip}), 128'({m_mac, m_ip}));
        end
    end

    // Transmitter emulation: finishes each frame after a random 4..8 cycles.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (rst_n && arp_tx_en && !tx_hold) begin
                d = $urandom_range(4, 8);
                repeat (d) @(posedge clk);
                #1;
                if (rst_n) tx_done = 1'b1;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_arp_tx_en"},    128'(arp_tx_en), 128'(0));
        chk({nm, "_arp_tx_type"},  128'(arp_tx_type), 128'(0));
        chk({nm, "_des_mac"},      128'(des_mac), 128'(0));
        chk({nm, "_des_ip"},       128'(des_ip), 128'(0));
        chk({nm, "_peer_valid"},   128'(peer_valid), 128'(0));
        chk({nm, "_peer_mac"},     128'(peer_mac), 128'(0));
        chk({nm, "_peer_ip"},      128'(peer_ip), 128'(0));
        chk({nm, "_busy"},         128'(busy), 128'(0));
        chk({nm, "_resolve_fail"}, 128'(resolve_fail), 128'(0));
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_valid = 1'b0;
        m_mac   = '0;
        m_ip    = '0;
    endtask

    task automatic do_reset(input string nm);
        if (exp_q.size() != 0)
            chk({nm, "_frames_left_before_reset"}, 128'(exp_q.size()), 128'(0));
        rst_n = 1'b0;
        clear_model();
        step(3);
        chk_all_zero(nm);
        rst_n = 1'b1;
    endtask

    // Drive one parsed ARP frame for a cycle; the model learns from it after the sampling edge.
    task automatic send_rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip,
                           input bit trig, input bit push);
        arp_rx_done = 1'b1;
        arp_rx_type = typ;
        src_mac     = mac;
        src_ip      = ip;
        req_trig    = trig;
        if (typ == 1'b0 && push) exp_q.push_back('{typ: 1'b1, mac: mac, ip: ip});
        @(posedge clk);
        #1;
        arp_rx_done = 1'b0;
        req_trig    = 1'b0;
        if (ip == PEER_IP) begin
            m_valid = 1'b1;
            m_mac   = mac;
            m_ip    = ip;
        end
    endtask

    task automatic pulse_trig();
        req_trig = 1'b1;
        step(1);
        req_trig = 1'b0;
    endtask

    task automatic wait_q_empty(input string nm, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (exp_q.size() == 0) return;
            step(1);
        end
        timeout_fail(nm);
    endtask

    task automatic wait_txd_after(input string nm, input int k, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (n_txd > k) return;
            step(1);
        end
        timeout_fail(nm);
    endtask

    task automatic wait_fail_after(input string nm, input int k, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (n_fail > k) return;
            step(1);
        end
        timeout_fail(nm);
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int stable;
        stable = 0;
        for (int i = 0; i < maxc; i++) begin
            step(1);
            if (!busy && exp_q.size() == 0 && !tx_done) stable++;
            else stable = 0;
            if (stable >= 3) return;
        end
        timeout_fail(nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog");
    end

    logic [47:0] mac_a, mac_b;
    logic [31:0] ip_a, ip_b;
    int          k, f0, fl0, lat, choice;

    initial begin
        step(1);
        do_reset("reset");

        // Request addressed to us: reply two cycles later with the sender's fields.
        send_rx(1'b0, 48'hA0_B1_C2_D3_E4_F5, 32'hC0A8_0166, 1'b0, 1'b1);
        lat = 1;
        while (!arp_tx_en && lat < 10) begin
            step(1);
            lat++;
        end
        chk("rx_req_latency", 128'(lat), 128'(2));
        chk("reply_type", 128'(arp_tx_type), 128'(1));
        chk("reply_des_mac", 128'(des_mac), 128'(48'hA0B1C2D3E4F5));
        chk("reply_des_ip", 128'(des_ip), 128'(32'hC0A80166));
        wait_idle("reply_idle", 50);
        chk("req_refresh_cache_mac", 128'(peer_mac), 128'(48'hA0B1C2D3E4F5));

        // Resolve with an answer inside the timeout window.
        do_reset("rst2");
        mac_a = rmac();
        fl0   = n_fail;
        pulse_trig();
        exp_q.push_back(req_frame());
        lat = 1;
        while (!arp_tx_en && lat < 10) begin
            step(1);
            lat++;
        end
        chk("trig_latency", 128'(lat), 128'(2));
        chk("req_des_mac", 128'(des_mac), 128'(48'hffff_ffff_ffff));
        chk("req_des_ip", 128'(des_ip), 128'(32'hC0A80166));
        chk("req_type", 128'(arp_tx_type), 128'(0));
        k = n_txd;
        wait_txd_after("req_txdone", k, 30);
        step($urandom_range(1, 45));
        send_rx(1'b1, mac_a, PEER_IP, 1'b0, 1'b0);
        step(2);
        chk("resolved_valid", 128'(peer_valid), 128'(1));
        chk("resolved_mac", 128'(peer_mac), 128'(mac_a));
        chk("resolved_busy", 128'(busy), 128'(0));
        step(TO + 20);
        chk("resolved_no_fail", 128'(n_fail), 128'(fl0));

        // No answer at all: every attempt times out, then one fail pulse.
        do_reset("rst3");
        fl0 = n_fail;
        f0  = n_frames;
        k   = n_txd;
        pulse_trig();
        for (int i = 0; i < N_ATT; i++) exp_q.push_back(req_frame());
        wait_txd_after("noans_txdone", k, 30);
        step(50);
        chk("noans_busy_waiting", 128'(busy), 128'(1));
        wait_fail_after("noans_fail", fl0, N_ATT * (TO + 30) + 50);
        step(20);
        chk("noans_fail_pulses", 128'(n_fail - fl0), 128'(1));
        chk("noans_frames", 128'(n_frames - f0), 128'(N_ATT));
        chk("noans_fail_delay", 128'((t_fail - t_txd >= TO) && (t_fail - t_txd <= TO + 2)), 128'(1));
        chk("noans_busy_after", 128'(busy), 128'(0));

        // Same-cycle request and trigger: reply goes out first.
        do_reset("rst4");
        f0    = n_frames;
        mac_b = rmac();
        ip_b  = $urandom();
        send_rx(1'b0, mac_b, ip_b, 1'b1, 1'b1);
        exp_q.push_back(req_frame());
        wait_q_empty("both_frames", 60);
        k = n_txd;
        wait_txd_after("both_txdone", k, 30);
        step(3);
        send_rx(1'b1, rmac(), PEER_IP, 1'b0, 1'b0);
        wait_idle("both_idle", 100);
        chk("both_frame_count", 128'(n_frames - f0), 128'(2));

        // Reset while the transmitter is still busy with a request.
        do_reset("rst5");
        tx_hold = 1'b1;
        pulse_trig();
        exp_q.push_back(req_frame());
        wait_q_empty("hold_frame", 20);
        step(2);
        chk("hold_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        clear_model();
        #2;
        chk_all_zero("async_rst");
        step(3);
        rst_n   = 1'b1;
        tx_hold = 1'b0;
        f0      = n_frames;
        step(2 * TO);
        chk("after_rst_no_frames", 128'(n_frames - f0), 128'(0));
        chk("after_rst_busy", 128'(busy), 128'(0));

        // Reply from a foreign IP while waiting: ignored, timeout still runs out.
        do_reset("rst6");
        fl0 = n_fail;
        k   = n_txd;
        pulse_trig();
        for (int i = 0; i < N_ATT; i++) exp_q.push_back(req_frame());
        wait_txd_after("foreign_txdone", k, 30);
        step(10);
        send_rx(1'b1, rmac(), 32'hC0A8_0137, 1'b0, 1'b0);
        step(2);
        chk("foreign_peer_valid", 128'(peer_valid), 128'(0));
        chk("foreign_busy", 128'(busy), 128'(1));
        wait_fail_after("foreign_fail", fl0, N_ATT * (TO + 30) + 50);
        step(5);
        chk("foreign_fail_pulses", 128'(n_fail - fl0), 128'(1));
        chk("foreign_frames_left", 128'(exp_q.size()), 128'(0));

        // Randomized mix of traffic from idle.
        do_reset("rst7");
        fl0 = n_fail;
        for (int it = 0; it < 24; it++) begin
            choice = $urandom_range(0, 3);
            mac_a  = rmac();
            ip_a   = ($urandom_range(0, 3) == 0) ? PEER_IP : $urandom();
            case (choice)
                0: send_rx(1'b0, mac_a, ip_a, 1'b0, 1'b1);
                1: send_rx(1'b1, mac_a, ip_a, 1'b0, 1'b0);
                2: begin
                    pulse_trig();
                    exp_q.push_back(req_frame());
                    wait_q_empty("rnd_req_frame", 20);
                    k = n_txd;
                    pulse_trig();
                    wait_txd_after("rnd_req_txdone", k, 30);
                    step($urandom_range(1, 40));
                    send_rx(1'b1, mac_a, PEER_IP, 1'b0, 1'b0);
                end
                default: begin
                    send_rx(1'b0, mac_a, ip_a, 1'b0, 1'b1);
                    wait_q_empty("rnd_first_reply", 20);
                    send_rx(1'b0, rmac(), $urandom(), 1'b0, 1'b0);
                    mac_b = rmac();
                    ip_b  = ($urandom_range(0, 1) == 0) ? PEER_IP : $urandom();
                    send_rx(1'b0, mac_b, ip_b, 1'b0, 1'b1);
                end
            endcase
            wait_idle("rnd_idle", 200);
        end
        chk("rnd_no_fail", 128'(n_fail), 128'(fl0));
        chk("rnd_frames_left", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
